// File: rtl/multi_channel_flatten_buffer.sv
// Scans a multi-channel time-surface memory cell by cell and captures the returned values
// into a flat feature vector, either at full resolution or 2x2 max-pooled per channel.
module multi_channel_flatten_buffer #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int NUM_CH     = 2,
    parameter int VALUE_BITS = 8,
    parameter int READ_LAT   = 2,
    localparam int CELLS = GRID_W * GRID_H,
    localparam int TOTAL = NUM_CH * CELLS,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(CELLS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        pool_en,
    input  logic                        abort,
    output logic [CW-1:0]               ts_ch,
    output logic [AW-1:0]               ts_addr,
    output logic                        ts_en,
    input  logic [VALUE_BITS-1:0]       ts_val,
    output logic                        busy,
    output logic                        flat_valid,
    output logic [TOTAL*VALUE_BITS-1:0] flat_data,
    output logic [15:0]                 frame_cnt
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int KW = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q;
    logic                  pool_q;
    logic [XW-1:0]         ix_q, ix_d;
    logic [YW-1:0]         iy_q, iy_d;
    logic [1:0]            iph_q, iph_d;
    logic [CW-1:0]         ich_d;
    logic [AW-1:0]         addr_d;
    logic [KW-1:0]         iss_cnt_q;
    logic                  ts_en_q;
    logic [CW-1:0]         ts_ch_q;
    logic [AW-1:0]         ts_addr_q;
    logic                  busy_q;
    logic                  flat_valid_q;
    logic [15:0]           frame_cnt_q;
    logic [READ_LAT-1:0]   vld_q, vld_d;
    logic [KW-1:0]         cap_k_q;
    logic [VALUE_BITS-1:0] acc_q, max_val;
    logic                  start_acc, abort_act, last_issue;
    logic                  cap_fire, wr_en;
    logic [KW-1:0]         wr_idx;
    logic [VALUE_BITS-1:0] wr_data;

    assign start_acc  = (state_q == IDLE) && start && !abort;
    assign abort_act  = (state_q != IDLE) && abort;
    assign last_issue = (iss_cnt_q == KW'(TOTAL - 1));
    assign vld_d      = READ_LAT'({vld_q, ts_en_q});

    // Next issue position. Base (x, y) steps by 2 in pool mode; the phase picks the quad member.
    always_comb begin
        ix_d  = ix_q;
        iy_d  = iy_q;
        iph_d = iph_q;
        ich_d = ts_ch_q;
        if (pool_q) begin
            if (iph_q != 2'd3) begin
                iph_d = iph_q + 2'd1;
            end else begin
                iph_d = 2'd0;
                if (ix_q == XW'(GRID_W - 2)) begin
                    ix_d = '0;
                    if (iy_q == YW'(GRID_H - 2)) begin
                        iy_d  = '0;
                        ich_d = ts_ch_q + 1'b1;
                    end else begin
                        iy_d = iy_q + YW'(2);
                    end
                end else begin
                    ix_d = ix_q + XW'(2);
                end
            end
        end else begin
            if (ix_q == XW'(GRID_W - 1)) begin
                ix_d = '0;
                if (iy_q == YW'(GRID_H - 1)) begin
                    iy_d  = '0;
                    ich_d = ts_ch_q + 1'b1;
                end else begin
                    iy_d = iy_q + 1'b1;
                end
            end else begin
                ix_d = ix_q + 1'b1;
            end
        end
        addr_d = AW'((32'(iy_d) + 32'(iph_d[1])) * GRID_W + 32'(ix_d) + 32'(iph_d[0]));
    end

    // Returns arrive in issue order, so one running index locates both the full-mode
    // entry and, divided by four, the pooled entry.
    assign max_val  = (ts_val > acc_q) ? ts_val : acc_q;
    assign cap_fire = vld_q[READ_LAT-1] && (state_q == ISSUE || state_q == DRAIN) && !abort_act;
    assign wr_en    = cap_fire && (!pool_q || cap_k_q[1:0] == 2'd3);
    assign wr_idx   = pool_q ? (cap_k_q >> 2) : cap_k_q;
    assign wr_data  = pool_q ? max_val : ts_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pool_q       <= 1'b0;
            ix_q         <= '0;
            iy_q         <= '0;
            iph_q        <= '0;
            iss_cnt_q    <= '0;
            ts_en_q      <= 1'b0;
            ts_ch_q      <= '0;
            ts_addr_q    <= '0;
            busy_q       <= 1'b0;
            flat_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            vld_q        <= '0;
            cap_k_q      <= '0;
            acc_q        <= '0;
        end else begin
            vld_q        <= vld_d;
            flat_valid_q <= 1'b0;
            if (cap_fire) begin
                cap_k_q <= cap_k_q + 1'b1;
                acc_q   <= (cap_k_q[1:0] == 2'd0) ? ts_val : max_val;
            end
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q   <= ISSUE;
                        pool_q    <= pool_en;
                        ts_en_q   <= 1'b1;
                        ts_ch_q   <= '0;
                        ts_addr_q <= '0;
                        ix_q      <= '0;
                        iy_q      <= '0;
                        iph_q     <= '0;
                        iss_cnt_q <= '0;
                        cap_k_q   <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state_q   <= DRAIN;
                        ts_en_q   <= 1'b0;
                        ts_ch_q   <= '0;
                        ts_addr_q <= '0;
                    end else begin
                        ix_q      <= ix_d;
                        iy_q      <= iy_d;
                        iph_q     <= iph_d;
                        ts_ch_q   <= ich_d;
                        ts_addr_q <= addr_d;
                        iss_cnt_q <= iss_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (vld_d == '0) begin
                        state_q      <= DONE;
                        flat_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
            if (abort_act) begin
                state_q      <= IDLE;
                ts_en_q      <= 1'b0;
                ts_ch_q      <= '0;
                ts_addr_q    <= '0;
                busy_q       <= 1'b0;
                flat_valid_q <= 1'b0;
                frame_cnt_q  <= frame_cnt_q;
                vld_q        <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_entry
        logic [VALUE_BITS-1:0] entry_q;
        always_ff @(posedge clk) begin
            if (!rst_n || start_acc) begin
                entry_q <= '0;
            end else if (wr_en && wr_idx == KW'(gi)) begin
                entry_q <= wr_data;
            end
        end
        assign flat_data[gi*VALUE_BITS +: VALUE_BITS] = entry_q;
    end

    assign ts_en      = ts_en_q;
    assign ts_ch      = ts_ch_q;
    assign ts_addr    = ts_addr_q;
    assign busy       = busy_q;
    assign flat_valid = flat_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_multi_channel_flatten_buffer.sv
// Three flatteners (read latency 2, 1, 4) share one stimulus stream on a 4x4x2 surface;
// results are compared against a spec-level model of issue order and captured vector.
module tb_multi_channel_flatten_buffer;

    localparam int W = 4, H = 4, NCH = 2, VB = 8;
    localparam int CELLS = W * H, TOTAL = NCH * CELLS;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, pool_en, abort;
    logic                  start_w    [NI];
    logic [0:0]            ts_ch_w    [NI];
    logic [3:0]            ts_addr_w  [NI];
    logic                  ts_en_w    [NI];
    logic [VB-1:0]         ts_val_w   [NI];
    logic                  busy_w     [NI];
    logic                  fv_w       [NI];
    logic [TOTAL*VB-1:0]   fd_w       [NI];
    logic [15:0]           fc_w       [NI];

    logic [VB-1:0] mem [NCH][CELLS];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int RL = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        logic [VB-1:0] pipe [RL];
        // Memory model: data for the request issued RL cycles earlier, garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= ts_en_w[gi] ? mem[ts_ch_w[gi]][ts_addr_w[gi]] : VB'($urandom);
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        end
        assign ts_val_w[gi] = pipe[RL-1];

        multi_channel_flatten_buffer #(
            .GRID_W(W), .GRID_H(H), .NUM_CH(NCH), .VALUE_BITS(VB), .READ_LAT(RL)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_w[gi]), .pool_en(pool_en), .abort(abort),
            .ts_ch(ts_ch_w[gi]), .ts_addr(ts_addr_w[gi]), .ts_en(ts_en_w[gi]),
            .ts_val(ts_val_w[gi]), .busy(busy_w[gi]), .flat_valid(fv_w[gi]),
            .flat_data(fd_w[gi]), .frame_cnt(fc_w[gi])
        );
    end

    int n_checks = 0, n_pass = 0;
    int fv_n [NI], fv_r [NI], fv2_r [NI], rs [NI];
    int bz_first [NI], bz_last [NI], en_first [NI], en_last [NI], ord_err [NI];
    logic prev_fv [NI];
    logic [15:0] fexp [NI];
    int e_ch [TOTAL], e_addr [TOTAL];
    logic [VB-1:0] exp_e [TOTAL];

    function automatic int rl_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s [u%0d]: observed %0d, expected %0d", tag, inst, obs, exp);
    endtask

    // Expected issue order and captured vector, built directly from the scan rules.
    task automatic build_model(input bit pool);
        int j = 0;
        for (int k = 0; k < TOTAL; k++) exp_e[k] = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!pool) begin
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++) begin
                        e_ch[j] = c; e_addr[j] = y*W + x; j++;
                        exp_e[c*CELLS + y*W + x] = mem[c][y*W + x];
                    end
            end else begin
                for (int py = 0; py < H/2; py++)
                    for (int px = 0; px < W/2; px++) begin
                        logic [VB-1:0] m = '0;
                        for (int d = 0; d < 4; d++) begin
                            int a = (2*py + d/2)*W + 2*px + d%2;
                            e_ch[j] = c; e_addr[j] = a; j++;
                            if (mem[c][a] > m) m = mem[c][a];
                        end
                        exp_e[c*(CELLS/4) + py*(W/2) + px] = m;
                    end
            end
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < CELLS; a++)
                mem[c][a] = rnd ? VB'($urandom) : VB'(c*16 + a);
    endtask

    task automatic run_scan(input bit pool, input int abort_r, input int busy_start_r, input bit chain);
        int rmax = chain ? 80 : 42;
        build_model(pool);
        for (int i = 0; i < NI; i++) begin
            fv_n[i] = 0; fv_r[i] = -1; fv2_r[i] = -1; rs[i] = -1; ord_err[i] = 0;
            bz_first[i] = -1; bz_last[i] = -1; en_first[i] = -1; en_last[i] = -1; prev_fv[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_w[i] = 1'b1;
        pool_en = pool;
        for (int r = 1; r <= rmax; r++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) start_w[i] = 1'b0;
            abort = 1'b0;
            for (int i = 0; i < NI; i++) begin
                bit first = (rs[i] < 0);
                if (fv_w[i]) begin
                    fv_n[i]++;
                    if (first) fv_r[i] = r; else fv2_r[i] = r;
                end
                if (first) begin
                    if (busy_w[i]) begin
                        if (bz_first[i] < 0) bz_first[i] = r;
                        bz_last[i] = r;
                    end
                    if (ts_en_w[i]) begin
                        if (en_first[i] < 0) en_first[i] = r;
                        en_last[i] = r;
                        if (r > TOTAL || int'(ts_ch_w[i]) != e_ch[r-1] || int'(ts_addr_w[i]) != e_addr[r-1])
                            ord_err[i]++;
                    end else if (ts_ch_w[i] != 1'b0 || ts_addr_w[i] != 4'd0) begin
                        ord_err[i]++;
                    end
                end
                if (chain && prev_fv[i] && rs[i] < 0) begin
                    start_w[i] = 1'b1;
                    rs[i] = r;
                end
                prev_fv[i] = fv_w[i];
            end
            if (r == abort_r) abort = 1'b1;
            if (r == busy_start_r) for (int i = 0; i < NI; i++) start_w[i] = 1'b1;
        end
        for (int i = 0; i < NI; i++) start_w[i] = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_scan(input string nm, input int abort_r, input bit chain, input bit chk_data);
        for (int i = 0; i < NI; i++) begin
            int lat = TOTAL + rl_of(i) + 1;
            if (abort_r > 0) begin
                chk({nm, "_fv_count"}, i, 64'(fv_n[i]), 64'd0);
                chk({nm, "_ts_en_last"}, i, 64'(en_last[i]), 64'(abort_r));
                chk({nm, "_busy_last"}, i, 64'(bz_last[i]), 64'(abort_r));
            end else begin
                chk({nm, "_fv_count"}, i, 64'(fv_n[i]), chain ? 64'd2 : 64'd1);
                chk({nm, "_fv_cycle"}, i, 64'(fv_r[i]), 64'(lat));
                chk({nm, "_busy_first"}, i, 64'(bz_first[i]), 64'd1);
                chk({nm, "_busy_last"}, i, 64'(bz_last[i]), 64'(lat - 1));
                chk({nm, "_ts_en_first"}, i, 64'(en_first[i]), 64'd1);
                chk({nm, "_ts_en_last"}, i, 64'(en_last[i]), 64'(TOTAL));
                chk({nm, "_issue_order_errs"}, i, 64'(ord_err[i]), 64'd0);
                fexp[i] = fexp[i] + 16'd1;
                if (chain) begin
                    chk({nm, "_restart_cycle"}, i, 64'(rs[i]), 64'(lat + 1));
                    chk({nm, "_fv2_latency"}, i, 64'(fv2_r[i] - rs[i]), 64'(lat));
                    fexp[i] = fexp[i] + 16'd1;
                end
                if (chk_data)
                    for (int k = 0; k < TOTAL; k++)
                        chk($sformatf("%s_entry%0d", nm, k), i, 64'(fd_w[i][k*VB +: VB]), 64'(exp_e[k]));
            end
            chk({nm, "_frame_cnt"}, i, 64'(fc_w[i]), 64'(fexp[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; pool_en = 1'b0; abort = 1'b0;
        for (int i = 0; i < NI; i++) begin start_w[i] = 1'b0; fexp[i] = 16'd0; end
        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, 64'(busy_w[i]), 64'd0);
            chk("rst_ts_en", i, 64'(ts_en_w[i]), 64'd0);
            chk("rst_ts_ch", i, 64'(ts_ch_w[i]), 64'd0);
            chk("rst_ts_addr", i, 64'(ts_addr_w[i]), 64'd0);
            chk("rst_flat_valid", i, 64'(fv_w[i]), 64'd0);
            chk("rst_frame_cnt", i, 64'(fc_w[i]), 64'd0);
            chk("rst_flat_data_zero", i, 64'(fd_w[i] == '0), 64'd1);
        end
        rst_n = 1'b1;

        // Directed full scan with a start pulse injected mid-scan (must be ignored).
        run_scan(1'b0, -1, 5, 1'b0);
        check_scan("full", -1, 1'b0, 1'b1);

        run_scan(1'b1, -1, -1, 1'b0);
        check_scan("pool", -1, 1'b0, 1'b1);

        // start together with abort in IDLE must not launch a scan.
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_w[i] = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_w[i] = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("start_abort_busy", i, 64'(busy_w[i]), 64'd0);
            chk("start_abort_ts_en", i, 64'(ts_en_w[i]), 64'd0);
        end

        run_scan(1'b0, 10, -1, 1'b0);
        check_scan("abort", 10, 1'b0, 1'b0);
        run_scan(1'b0, -1, -1, 1'b0);
        check_scan("post_abort", -1, 1'b0, 1'b1);

        fill_mem(1'b1);
        run_scan(1'b0, -1, -1, 1'b1);
        check_scan("b2b", -1, 1'b1, 1'b1);

        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            fill_mem(1'b1);
            run_scan((t == 0) ? 1'b1 : 1'($urandom_range(0, 1)), -1, -1, 1'b0);
            check_scan($sformatf("rand%0d", t), -1, 1'b0, 1'b1);
        end

        // Frame counter wrap from a preset 0xFFFF.
        @(negedge clk);
        force g_dut[0].u_dut.frame_cnt_q = 16'hFFFF;
        force g_dut[1].u_dut.frame_cnt_q = 16'hFFFF;
        force g_dut[2].u_dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].u_dut.frame_cnt_q;
        release g_dut[1].u_dut.frame_cnt_q;
        release g_dut[2].u_dut.frame_cnt_q;
        for (int i = 0; i < NI; i++) fexp[i] = 16'hFFFF;
        run_scan(1'b0, -1, -1, 1'b0);
        check_scan("wrap", -1, 1'b0, 1'b0);

        // Reset asserted mid-ISSUE.
        fill_mem(1'b0);
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_w[i] = 1'b1;
        pool_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_w[i] = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("midrst_busy", i, 64'(busy_w[i]), 64'd0);
            chk("midrst_ts_en", i, 64'(ts_en_w[i]), 64'd0);
            chk("midrst_ts_ch", i, 64'(ts_ch_w[i]), 64'd0);
            chk("midrst_ts_addr", i, 64'(ts_addr_w[i]), 64'd0);
            chk("midrst_flat_valid", i, 64'(fv_w[i]), 64'd0);
            chk("midrst_frame_cnt", i, 64'(fc_w[i]), 64'd0);
            chk("midrst_flat_data_zero", i, 64'(fd_w[i] == '0), 64'd1);
            fexp[i] = 16'd0;
        end
        rst_n = 1'b1;
        run_scan(1'b0, -1, -1, 1'b0);
        check_scan("after_rst", -1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_flatten_buffer.md
# multi_channel_flatten_buffer

Scans every cell of a multi-channel (per-polarity) time-surface memory and captures the decayed values into a flat vector for the classifier front end. It extends the single-channel flattener in four ways:
- rectangular grid and configurable channel count;
- configurable memory read latency;
- runtime-selectable 2x2 max-pool mode;
- abort, busy and frame-count signalling.

It sits between the time-surface BRAM/decay pipeline and the feature/classifier input register.

## Interface
- GRID_W, 16, grid width in cells (even)
- GRID_H, 16, grid height in cells (even)
- NUM_CH, 2, number of time-surface channels
- VALUE_BITS, 8, width of one cell value
- READ_LAT, 2, cycles from ts_en to valid ts_val (legal 1..4)
- Derived: CELLS = GRID_W*GRID_H; TOTAL = NUM_CH*CELLS; CW = max(1,$clog2(NUM_CH)); AW = $clog2(CELLS)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  scan request pulse, accepted only in IDLE
- pool_en  in  1  sampled at accepted start: 0 = full resolution, 1 = 2x2 max-pool
- abort  in  1  cancel scan; wins over start in the same cycle
- ts_ch  out  CW  channel being read
- ts_addr  out  AW  cell index y*GRID_W+x
- ts_en  out  1  read strobe
- ts_val  in  VALUE_BITS  read data, READ_LAT cycles after ts_en
- busy  out  1  scan in progress
- flat_valid  out  1  one-cycle pulse, flat_data complete
- flat_data  out  TOTAL*VALUE_BITS  entry k at bits [k*VALUE_BITS +: VALUE_BITS]
- frame_cnt  out  16  count of completed scans, wraps 0xFFFF->0

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start && !abort. On this transition:
  - latch pool_en;
  - clear all flat_data entries to 0;
  - reset issue and capture indices.
- ISSUE: one read per cycle, ts_en=1. TOTAL issues in total.
  - Full mode order: channel-major, then row-major (y, then x).
  - Pool mode order: channel-major, then pooled cell (py, px) row-major. Each pooled cell issues its four cells in order (2py,2px), (2py,2px+1), (2py+1,2px), (2py+1,2px+1).
- ISSUE -> DRAIN after the last issue; ts_en=0 and ts_addr=0 in DRAIN.
- In-flight tracking: a READ_LAT-deep valid shift register fed by ts_en. ts_val is captured in the cycle its tail bit is 1.
- Full-mode capture: entry[ch*CELLS + cell] <= ts_val, in issue order.
- Pool-mode capture:
  - accumulator = ts_val on phase 0, otherwise max(acc, ts_val) (unsigned);
  - on phase 3, entry[ch*(CELLS/4) + py*(GRID_W/2) + px] <= max;
  - entries at index >= TOTAL/4 stay 0.
- DRAIN -> DONE when the shift register is empty.
- DONE: flat_valid=1 for exactly one cycle, frame_cnt += 1, then -> IDLE.
- abort in ISSUE/DRAIN/DONE:
  - -> IDLE next cycle; ts_en=0 next cycle;
  - in-flight returns are discarded;
  - no flat_valid, frame_cnt unchanged;
  - flat_data holds partial contents (undefined for use).
- start while busy is ignored (not queued).

## Timing
- Reset values:
  - state IDLE, busy 0, ts_en 0, ts_ch 0, ts_addr 0;
  - flat_valid 0, frame_cnt 0, all flat_data 0, pipeline empty.
- Start accepted at cycle 0:
  - ts_en high in cycles 1..TOTAL;
  - captures in cycles 1+READ_LAT..TOTAL+READ_LAT;
  - flat_valid at cycle TOTAL+READ_LAT+1.
- The latency above is identical in both modes.
- busy = 1 in cycles 1..TOTAL+READ_LAT; busy = 0 in the flat_valid cycle.
- A new start is accepted the cycle after flat_valid.
- flat_data is stable whenever busy = 0 and no start is being accepted.
- ts_ch, ts_addr and ts_en are registered outputs.

## Test plan
All scenarios use GRID_W=GRID_H=4, NUM_CH=2, READ_LAT=2 (TOTAL=32). The memory model returns ts_val = ch*16 + addr, READ_LAT cycles after each ts_en.
- Full scan: start, pool_en=0 -> entry k = k for k=0..31; flat_valid only at cycle 35; busy in cycles 1..34; frame_cnt = 1.
- Pool scan: start, pool_en=1 -> entries 0..7 = 5, 7, 13, 15, 21, 23, 29, 31; entries 8..31 = 0; flat_valid at cycle 35.
- Abort at cycle 10 -> ts_en=0 at cycle 11; no flat_valid; busy=0 from cycle 11; frame_cnt unchanged; a following full scan produces entry k = k.
- Start asserted during a busy scan, and start+abort together in IDLE -> both ignored; exactly one flat_valid per accepted start.
- Back-to-back scans: start the cycle after flat_valid -> second flat_valid 35 cycles later; frame_cnt = 2. Also check frame_cnt wrap with a forced start value of 0xFFFF -> 0.
- Reset: rst_n=0 mid-ISSUE -> next cycle all outputs at reset values and flat_data all 0. Repeat the full scan with READ_LAT=1 and READ_LAT=4 -> flat_valid at cycles 34 and 37.
